// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with in-order memory responses and redirect flush.
// Define FETCH_QUEUE_BYPASS_EN to forward a response arriving at an empty queue straight onto inst_*.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h2000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [31:0]   addr_q, addr_d, resp_pc_q, resp_pc_d;
  logic          accept, resp_keep, bypass, push, pop, head_valid;
  assign head_valid     = count_q != '0;
  // inflight counts every outstanding response, including those already marked for discard
  assign imem_req_valid = reset && !redirect_valid &&
                          (({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
  assign imem_addr      = addr_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign resp_keep      = reset && imem_resp_valid && discard_q == '0 && !redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass         = resp_keep && !head_valid;
`else
  assign bypass         = 1'b0;
`endif
  assign inst_valid     = head_valid || bypass;
  assign inst_data      = head_valid ? data_q[head_q] : bypass ? imem_resp_data : '0;
  assign inst_pc        = head_valid ? pc_q[head_q] : bypass ? resp_pc_q : '0;
  assign pop            = head_valid && inst_ready && !redirect_valid;
  assign push           = resp_keep && !(bypass && inst_ready);
  always_comb begin
    inflight_d = inflight_q + CW'(accept) - CW'(imem_resp_valid);
    addr_d     = redirect_valid ? redirect_pc : accept ? addr_q + 32'd4 : addr_q;
    resp_pc_d  = redirect_valid ? redirect_pc : resp_keep ? resp_pc_q + 32'd4 : resp_pc_q;
    discard_d  = redirect_valid ? inflight_d :
                 (imem_resp_valid && discard_q != '0) ? discard_q - CW'(1) : discard_q;
    count_d    = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    head_d     = redirect_valid ? '0 : head_q + AW'(pop);
    tail_d     = redirect_valid ? '0 : tail_q + AW'(push);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      addr_q     <= addr_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q] <= imem_resp_data;
      pc_q[tail_q]   <= resp_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against an in-order PC stream model.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h2000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, accepted = 0, consumed = 0, lat_min = 1, lat_max = 1;
  logic [31:0] pend_addr[$];
  int          pend_time[$];
  logic [31:0] exp_pc = 32'h2000, fetch_exp = 32'h2000, last_pc = '0;
  logic        o_rv, o_iv, o_resp, o_acc;
  logic [31:0] o_addr, o_pc, o_data;
  logic        p_rv = 0, p_acc = 0, p_iv = 0, p_ir = 0, p_redir = 0;
  logic [31:0] p_addr = '0, p_pc = '0, p_data = '0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: observe at negedge, update memory model after the posedge.
  task automatic cycle();
    @(negedge clk);
    o_rv = imem_req_valid; o_addr = imem_addr; o_iv = inst_valid;
    o_pc = inst_pc; o_data = inst_data; o_resp = imem_resp_valid;
    o_acc = o_rv && imem_req_ready;
    if (p_iv && !p_ir && !p_redir) begin
      chk("hold_valid", o_iv, 1);
      chk("hold_pc", o_pc, p_pc);
      chk("hold_data", o_data, p_data);
    end
    if (p_rv && !p_acc && !p_redir && o_rv) chk("hold_addr", o_addr, p_addr);
    if (redirect_valid) chk("req_blocked", o_rv, 0);
    if (o_acc) begin
      chk("fetch_addr", o_addr, fetch_exp);
      fetch_exp += 32'd4;
      accepted++;
    end
    if (o_iv && inst_ready && !redirect_valid) begin
      chk("inst_pc", o_pc, exp_pc);
      chk("inst_data", o_data, word_at(exp_pc));
      exp_pc += 32'd4;
      last_pc = o_pc;
      consumed++;
    end
    if (redirect_valid) begin
      exp_pc = redirect_pc;
      fetch_exp = redirect_pc;
    end
    p_rv = o_rv; p_acc = o_acc; p_addr = o_addr; p_iv = o_iv; p_ir = inst_ready;
    p_redir = redirect_valid; p_pc = o_pc; p_data = o_data;
    @(posedge clk);
    #1;
    cyc++;
    if (o_resp) begin
      void'(pend_addr.pop_front());
      void'(pend_time.pop_front());
    end
    if (o_acc) begin
      pend_addr.push_back(o_addr);
      pend_time.push_back(cyc + $urandom_range(lat_max, lat_min) - 1);
    end
    imem_resp_valid = pend_addr.size() != 0 && pend_time[0] <= cyc;
    imem_resp_data  = imem_resp_valid ? word_at(pend_addr[0]) : '0;
  endtask

  initial begin
    int c0, a0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_addr", imem_addr, 32'h2000);
    reset = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    #1;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_addr, 32'h2000);

    // single-cycle memory, always ready: one instruction per cycle once primed
    repeat (4) cycle();
    c0 = consumed;
    repeat (12) cycle();
    chk("throughput", consumed - c0, 12);

    // decode stall: queue fills to DEPTH, fetch stops, head holds
    inst_ready = 1'b0;
    repeat (10) cycle();
    chk("fill_outstanding", accepted - consumed, 4);
    chk("fill_req_off", o_rv, 0);
    chk("fill_head_pc", o_pc, exp_pc);
    inst_ready = 1'b1;
    c0 = consumed;
    repeat (4) cycle();
    chk("fill_drain", consumed - c0, 4);

    // two requests in flight with 3-cycle latency, then redirect
    imem_req_ready = 1'b0;
    repeat (8) cycle();
    chk("drained", o_iv, 0);
    lat_min = 3; lat_max = 3;
    imem_req_ready = 1'b1;
    a0 = accepted;
    cycle(); cycle();
    chk("two_inflight", accepted - a0, 2);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3000;
    cycle();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    c0 = consumed;
    repeat (20) if (consumed == c0) cycle();
    chk("redir_first_pc", last_pc, 32'h3000);
    chk("redir_delivered", consumed - c0, 1);

    // redirect coinciding with dequeue and response
    lat_min = 1; lat_max = 1;
    repeat (6) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    cycle();
    chk("coinc_resp", o_resp, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("coinc_iv", o_iv, 0);
`else
    chk("coinc_iv", o_iv, 1);
`endif
    redirect_valid = 1'b0;
    c0 = consumed;
    cycle();
    chk("coinc_next_iv", o_iv, 0);
    chk("coinc_no_deliver", consumed - c0, 0);
    repeat (6) cycle();
    chk("coinc_resume", consumed > c0, 1);

    // single response into an empty queue with decode ready
    imem_req_ready = 1'b0;
    repeat (8) cycle();
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    cycle();
    chk("empty_resp", o_resp, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass_same_cycle", o_iv, 1);
    cycle();
    chk("bypass_next_cycle", o_iv, 0);
`else
    chk("nobypass_same_cycle", o_iv, 0);
    cycle();
    chk("nobypass_next_cycle", o_iv, 1);
`endif

    // randomized ready/latency/decode/redirect against the PC stream model
    lat_min = 1; lat_max = 4;
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = $urandom_range(0, 3) != 0;
      inst_ready     = $urandom_range(0, 2) != 0;
      redirect_valid = $urandom_range(0, 39) == 0;
      redirect_pc    = $urandom_range(0, 1) ? ($urandom() & 32'hFFFF_FFFC) : 32'hFFFF_FFF0;
      cycle();
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1; lat_min = 1; lat_max = 1;
    repeat (20) cycle();
    chk("random_progress", consumed - c0 > 500, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
